// File: rtl/vga_pkg.sv
// Shared PS/2 set-2 definitions: tracked-key table, protocol prefix bytes and key lookup.
package vga_pkg;

  localparam logic [7:0] SC_EXT     = 8'hE0;
  localparam logic [7:0] SC_BRK     = 8'hF0;
  localparam logic [7:0] SC_PAUSE   = 8'hE1;
  localparam int         PAUSE_SKIP = 7;
  localparam int         N_TABLE    = 16;

  localparam int KEY_IDX_A        = 0;
  localparam int KEY_IDX_S        = 1;
  localparam int KEY_IDX_D        = 2;
  localparam int KEY_IDX_W        = 3;
  localparam int KEY_IDX_1        = 4;
  localparam int KEY_IDX_2        = 5;
  localparam int KEY_IDX_3        = 6;
  localparam int KEY_IDX_4        = 7;
  localparam int KEY_IDX_ESC      = 8;
  localparam int KEY_IDX_UP       = 9;
  localparam int KEY_IDX_DOWN     = 10;
  localparam int KEY_IDX_LEFT     = 11;
  localparam int KEY_IDX_RIGHT    = 12;
  localparam int KEY_IDX_SPACE    = 13;
  localparam int KEY_IDX_ENTER    = 14;
  localparam int KEY_IDX_KP_ENTER = 15;

  typedef struct packed {
    logic       ext;
    logic [7:0] code;
  } key_code_t;

  typedef struct packed {
    logic       hit;
    logic [3:0] idx;
  } key_hit_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_PAUSE
  } parse_state_t;

  localparam key_code_t KEY_TABLE [N_TABLE] = '{
    '{1'b0, 8'h1C}, '{1'b0, 8'h1B}, '{1'b0, 8'h23}, '{1'b0, 8'h1D},
    '{1'b0, 8'h16}, '{1'b0, 8'h1E}, '{1'b0, 8'h26}, '{1'b0, 8'h25},
    '{1'b0, 8'h76}, '{1'b1, 8'h75}, '{1'b1, 8'h72}, '{1'b1, 8'h6B},
    '{1'b1, 8'h74}, '{1'b0, 8'h29}, '{1'b0, 8'h5A}, '{1'b1, 8'h5A}
  };

  // Lowest matching table index wins; entries are unique so order only matters for determinism.
  function automatic key_hit_t key_lookup(input logic ext, input logic [7:0] code);
    key_hit_t r;
    r = '0;
    for (int i = N_TABLE - 1; i >= 0; i--) begin
      if (KEY_TABLE[i].ext == ext && KEY_TABLE[i].code == code) begin
        r.hit = 1'b1;
        r.idx = 4'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ps2_key_tracker_if.sv
// Byte input, held-key bitmap and event handshake of the key tracker.
interface ps2_key_tracker_if #(
    parameter int N_KEYS = 16,
    parameter int KEY_W  = 4
);
    logic              rx_done_tick;
    logic [7:0]        dout;
    logic [N_KEYS-1:0] key_down;
    logic              ev_valid;
    logic              ev_ready;
    logic [KEY_W-1:0]  ev_key;
    logic              ev_make;
    logic              ev_repeat;
    logic              overflow;

    modport master (
        input  rx_done_tick, dout, ev_ready,
        output key_down, ev_valid, ev_key, ev_make, ev_repeat, overflow
    );

    modport slave (
        output rx_done_tick, dout, ev_ready,
        input  key_down, ev_valid, ev_key, ev_make, ev_repeat, overflow
    );
endinterface

// File: rtl/ps2_event_fifo.sv
// First-word-fall-through synchronous FIFO with count-based full/empty; head reads as zero when empty.
module ps2_event_fifo #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 set-2 scancode parser: tracks held keys and queues press/release events.
module ps2_key_tracker
    import vga_pkg::*;
#(
    parameter int N_KEYS     = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int REPEAT_EN  = 0
) (
    input  logic                clk,
    input  logic                rst,
    ps2_key_tracker_if.master   bus
);
    localparam int KEY_W = (N_KEYS > 1) ? $clog2(N_KEYS) : 1;
    localparam int EV_W  = KEY_W + 2;

    parse_state_t      state, state_n;
    logic [2:0]        skip_cnt, skip_cnt_n;
    logic [N_KEYS-1:0] key_down_r, key_down_n;
    logic              overflow_r;
    logic              key_vld, key_ext, key_brk, key_sel;
    key_hit_t          hit;
    logic [KEY_W-1:0]  idx;
    logic              push;
    logic [EV_W-1:0]   ev_din, ev_head;
    logic              fifo_full, fifo_empty, pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            skip_cnt   <= '0;
            key_down_r <= '0;
            overflow_r <= 1'b0;
        end else begin
            state      <= state_n;
            skip_cnt   <= skip_cnt_n;
            key_down_r <= key_down_n;
            if (push && fifo_full && !pop) overflow_r <= 1'b1;
        end
    end

    always_comb begin
        state_n    = state;
        skip_cnt_n = skip_cnt;
        key_vld    = 1'b0;
        key_ext    = 1'b0;
        key_brk    = 1'b0;
        if (bus.rx_done_tick) begin
            case (state)
                ST_IDLE: begin
                    if (bus.dout == SC_EXT)        state_n = ST_EXT;
                    else if (bus.dout == SC_BRK)   state_n = ST_BRK;
                    else if (bus.dout == SC_PAUSE) begin
                        state_n    = ST_PAUSE;
                        skip_cnt_n = 3'(PAUSE_SKIP);
                    end else key_vld = 1'b1;
                end
                ST_EXT: begin
                    if (bus.dout == SC_BRK) state_n = ST_EXT_BRK;
                    else if (bus.dout != SC_EXT) begin
                        key_vld = 1'b1;
                        key_ext = 1'b1;
                        state_n = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    key_vld = 1'b1;
                    key_brk = 1'b1;
                    state_n = ST_IDLE;
                end
                ST_EXT_BRK: begin
                    key_vld = 1'b1;
                    key_ext = 1'b1;
                    key_brk = 1'b1;
                    state_n = ST_IDLE;
                end
                ST_PAUSE: begin
                    // Pause bytes are swallowed whole; they carry no make/break meaning.
                    skip_cnt_n = skip_cnt - 1'b1;
                    if (skip_cnt <= 3'd1) state_n = ST_IDLE;
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    assign hit     = key_lookup(key_ext, bus.dout);
    assign idx     = hit.idx[KEY_W-1:0];
    assign key_sel = key_vld && hit.hit && (int'(hit.idx) < N_KEYS);

    always_comb begin
        key_down_n = key_down_r;
        push       = 1'b0;
        ev_din     = '0;
        if (key_sel) begin
            if (key_brk) begin
                key_down_n[idx] = 1'b0;
                push            = 1'b1;
                ev_din          = {idx, 1'b0, 1'b0};
            end else if (!key_down_r[idx]) begin
                key_down_n[idx] = 1'b1;
                push            = 1'b1;
                ev_din          = {idx, 1'b1, 1'b0};
            end else if (REPEAT_EN != 0) begin
                push   = 1'b1;
                ev_din = {idx, 1'b1, 1'b1};
            end
        end
    end

    assign pop = !fifo_empty && bus.ev_ready;

    ps2_event_fifo #(
        .WIDTH (EV_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (ev_din),
        .pop   (pop),
        .dout  (ev_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.key_down = key_down_r;
    assign bus.overflow = overflow_r;
    assign bus.ev_valid = !fifo_empty;
    assign {bus.ev_key, bus.ev_make, bus.ev_repeat} = ev_head;
endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker: two instances (repeats dropped / repeats queued) share one byte stream.
module tb_ps2_key_tracker;
    import vga_pkg::*;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] rx_byte;
    logic       ready;
    int         tests = 0;
    int         fails = 0;
    logic [5:0] q0[$];
    logic [5:0] q1[$];

    ps2_key_tracker_if #(.N_KEYS(16), .KEY_W(4)) b0 ();
    ps2_key_tracker_if #(.N_KEYS(16), .KEY_W(4)) b1 ();

    assign b0.rx_done_tick = rx;
    assign b0.dout         = rx_byte;
    assign b0.ev_ready     = ready;
    assign b1.rx_done_tick = rx;
    assign b1.dout         = rx_byte;
    assign b1.ev_ready     = ready;

    ps2_key_tracker #(.N_KEYS(16), .FIFO_DEPTH(8), .REPEAT_EN(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    ps2_key_tracker #(.N_KEYS(16), .FIFO_DEPTH(8), .REPEAT_EN(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx      = 1'b1;
        rx_byte = b;
        @(posedge clk);
        #1;
        rx      = 1'b0;
        rx_byte = 8'h00;
    endtask

    task automatic exp_both(input int k, input logic m, input logic r);
        q0.push_back({4'(k), m, r});
        q1.push_back({4'(k), m, r});
    endtask

    // Pop each instance's head against its own expectation queue until both are exhausted.
    task automatic drain(input string tag);
        int budget;
        logic [5:0] e;
        budget = 0;
        ready  = 1'b1;
        while ((q0.size() > 0 || q1.size() > 0) && budget < 200) begin
            @(negedge clk);
            if (b0.ev_valid) begin
                e = (q0.size() > 0) ? q0.pop_front() : 6'h3F;
                check({tag, "_ev0"}, {26'd0, b0.ev_key, b0.ev_make, b0.ev_repeat}, {26'd0, e});
            end
            if (b1.ev_valid) begin
                e = (q1.size() > 0) ? q1.pop_front() : 6'h3F;
                check({tag, "_ev1"}, {26'd0, b1.ev_key, b1.ev_make, b1.ev_repeat}, {26'd0, e});
            end
            budget++;
        end
        check({tag, "_pending"}, q0.size() + q1.size(), 0);
        @(posedge clk);
        #1;
        ready = 1'b0;
        check({tag, "_empty0"}, b0.ev_valid, 0);
        check({tag, "_empty1"}, b1.ev_valid, 0);
    endtask

    initial begin
        rx      = 1'b0;
        rx_byte = 8'h00;
        ready   = 1'b0;
        rst     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_key_down", b0.key_down, 0);
        check("rst_ev_valid", b0.ev_valid, 0);
        check("rst_ev_key", b0.ev_key, 0);
        check("rst_ev_make", b0.ev_make, 0);
        check("rst_ev_repeat", b0.ev_repeat, 0);
        check("rst_overflow", b0.overflow, 0);

        // Press and release A with one-cycle latency.
        send(8'h1C);
        check("a_make_key_down", b0.key_down, 16'h0001);
        check("a_make_latency", b0.ev_valid, 1);
        exp_both(KEY_IDX_A, 1'b1, 1'b0);
        drain("a_make");
        send(SC_BRK);
        send(8'h1C);
        check("a_brk_key_down", b0.key_down, 16'h0000);
        exp_both(KEY_IDX_A, 1'b0, 1'b0);
        drain("a_brk");

        // Several keys held at once, extended code included.
        send(8'h1D);
        send(SC_EXT);
        send(8'h75);
        send(SC_BRK);
        send(8'h1D);
        check("multi_key_down", b0.key_down, 16'h0200);
        exp_both(KEY_IDX_W, 1'b1, 1'b0);
        exp_both(KEY_IDX_UP, 1'b1, 1'b0);
        exp_both(KEY_IDX_W, 1'b0, 1'b0);
        drain("multi");
        send(SC_EXT);
        send(SC_BRK);
        send(8'h75);
        check("up_brk_key_down", b0.key_down, 16'h0000);
        exp_both(KEY_IDX_UP, 1'b0, 1'b0);
        drain("up_brk");

        // Typematic repeat: dropped on dut0, queued with repeat flag on dut1.
        send(8'h1B);
        send(8'h1B);
        send(8'h1B);
        check("rep_key_down0", b0.key_down, 16'h0002);
        check("rep_key_down1", b1.key_down, 16'h0002);
        exp_both(KEY_IDX_S, 1'b1, 1'b0);
        q1.push_back({4'(KEY_IDX_S), 1'b1, 1'b1});
        q1.push_back({4'(KEY_IDX_S), 1'b1, 1'b1});
        drain("repeat");
        send(SC_BRK);
        send(8'h1B);
        exp_both(KEY_IDX_S, 1'b0, 1'b0);
        drain("s_brk");

        // Pause sequence produces nothing; SPACE afterwards is parsed normally.
        send(SC_PAUSE);
        send(8'h14);
        send(8'h77);
        send(SC_PAUSE);
        send(SC_BRK);
        send(8'h14);
        send(SC_BRK);
        send(8'h77);
        check("pause_silent", b0.ev_valid, 0);
        send(8'h29);
        check("pause_key_down", b0.key_down, 16'h2000);
        exp_both(KEY_IDX_SPACE, 1'b1, 1'b0);
        drain("pause");

        // Release SPACE, then fill the FIFO past its depth with ready low.
        send(SC_BRK);
        send(8'h29);
        exp_both(KEY_IDX_SPACE, 1'b0, 1'b0);
        drain("space_brk");
        send(8'h1C);
        send(8'h1B);
        send(8'h23);
        send(8'h1D);
        send(8'h16);
        send(8'h1E);
        send(8'h26);
        send(8'h25);
        send(8'h76);
        check("ovf_key_down", b0.key_down, 16'h01FF);
        check("ovf_flag0", b0.overflow, 1);
        check("ovf_flag1", b1.overflow, 1);
        repeat (3) @(posedge clk);
        #1;
        check("ovf_hold_valid", b0.ev_valid, 1);
        check("ovf_hold_key", b0.ev_key, 0);
        check("ovf_hold_make", b0.ev_make, 1);
        for (int i = 0; i < 8; i++) exp_both(i, 1'b1, 1'b0);
        drain("ovf_drain");
        check("ovf_sticky", b0.overflow, 1);

        // Reset between E0 and the final byte discards the partial sequence.
        send(SC_EXT);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_key_down", b0.key_down, 0);
        check("midrst_overflow", b0.overflow, 0);
        send(8'h75);
        repeat (2) @(posedge clk);
        #1;
        check("midrst_no_ev0", b0.ev_valid, 0);
        check("midrst_no_ev1", b1.ev_valid, 0);
        check("midrst_key_down2", b0.key_down, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ps2_key_tracker.md
# ps2_key_tracker

Parametrised PS/2 set-2 scancode decoder that sits after the PS/2 receiver (`rx_done_tick`/`dout`) and feeds game and menu logic. It handles make, break (`F0`), extended (`E0`) and Pause (`E1`) sequences. It maintains a held-key bitmap so several keys can be down at once, and it queues press/release events in a small FIFO with a valid/ready handshake.

## Interface
Parameters:
- `N_KEYS`, 16: number of tracked keys, 1..16. Indices map to the first `N_KEYS` entries of the package table.
- `FIFO_DEPTH`, 8: event FIFO depth, power of two, ≥2.
- `REPEAT_EN`, 0: 1 enqueues typematic repeats (make of a held key) with `ev_repeat=1`; 0 drops them.

Ports (reset `rst`, synchronous, active-high; clock `clk`):
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `rx_done_tick` in 1: one-cycle strobe; `dout` is valid while it is high.
- `dout` in 8: received scancode byte.
- `key_down` out `N_KEYS`: bit i = key i currently held.
- `ev_valid` out 1: FIFO head is valid.
- `ev_ready` in 1: consumer accepts the head.
- `ev_key` out `$clog2(N_KEYS)` (min 1): key index of the head event.
- `ev_make` out 1: 1 = press, 0 = release.
- `ev_repeat` out 1: head event is a typematic repeat.
- `overflow` out 1: sticky; set when an event is dropped because the FIFO is full.

## Operation
- Parser FSM advances only on `rx_done_tick`:
  - IDLE: `E0`→EXT; `F0`→BRK; `E1`→PAUSE (skip count=7); any other byte is a make of a non-extended code, stay IDLE.
  - EXT: `F0`→EXT_BRK; `E0` ignored, stay EXT; any other byte is an extended make, →IDLE.
  - BRK: any byte is a non-extended break, →IDLE.
  - EXT_BRK: any byte is an extended break, →IDLE.
  - PAUSE: decrement skip count per byte; at 0 →IDLE. No events, no `key_down` change.
- Lookup: the {ext, code} pair is matched against the package table. No match, or index ≥ `N_KEYS`, means the byte is ignored (no event, no bitmap change, FSM still returns to IDLE).
- Make of key i with `key_down[i]=0`: set bit, enqueue {i, make=1, repeat=0}.
- Make of key i with `key_down[i]=1`: enqueue {i,1,1} only if `REPEAT_EN`; the bitmap is unchanged.
- Break of key i: clear bit, enqueue {i,0,0}. A break of a key that is not held is still enqueued.
- FIFO: first-word-fall-through. Pop occurs when `ev_valid && ev_ready`.
  - Push while full with no pop in the same cycle: event is dropped, `overflow` is set, `key_down` still updates.
  - Simultaneous push and pop while full: both succeed, no overflow.
  - Simultaneous push and pop while empty: the pushed event becomes the head the next cycle.
- `ev_*` outputs are don't-care while `ev_valid=0`. Outputs must not change while `ev_valid && !ev_ready`.

## Timing
- Reset values: `key_down=0`, `ev_valid=0`, `ev_key=0`, `ev_make=0`, `ev_repeat=0`, `overflow=0`. FSM goes to IDLE, FIFO is emptied, skip count is cleared.
- Latency: from the cycle of the final byte's `rx_done_tick`, `key_down` updates at the next edge, and `ev_valid` rises at the next edge when the FIFO was empty (1 cycle).
- Throughput: one byte per cycle is accepted. Back-to-back `rx_done_tick` must work.
- `overflow` clears only on `rst`.
- Reset mid-sequence (for example after `E0`, before the final byte) discards the partial sequence. The next byte is parsed from IDLE.

## Structure
- `vga_pkg` holds:
  - the key table: 16 entries of {ext, code}, in order A 1C, S 1B, D 23, W 1D, 1 16, 2 1E, 3 26, 4 25, ESC 76, UP E0 75, DOWN E0 72, LEFT E0 6B, RIGHT E0 74, SPACE 29, ENTER 5A, KP_ENTER E0 5A;
  - the index constants `KEY_IDX_*`;
  - the constants `SC_EXT=8'hE0`, `SC_BRK=8'hF0`, `SC_PAUSE=8'hE1`, `PAUSE_SKIP=7`;
  - the lookup function.
- Sub-module `ps2_event_fifo`: parametrised sync FIFO with width and depth parameters, FWFT, and count-based full/empty.

## Test plan
- Press A: feed 1C → `key_down[0]=1` one cycle later; event {0,1,0}. Feed F0,1C → bit cleared; event {0,0,0}.
- Multi-key: press W (1D) and UP (E0 75), then release W (F0 1D) → `key_down`=0x0200; three events in order.
- Repeat: press S, then 1B twice more, with `REPEAT_EN=0` → one event; with `REPEAT_EN=1` → three events, the last two with `ev_repeat=1`.
- Pause: feed E1 14 77 E1 F0 14 F0 77, then 29 → only SPACE {13,1,0} is queued; `key_down[13]=1`.
- Overflow: `FIFO_DEPTH=8` with `ev_ready=0`, send 9 distinct makes → 8 held, `overflow=1`, `key_down` has 9 bits set. Then `ev_ready=1` → the 8 events drain in order.
- Reset between E0 and 75 → no event. A following 75 alone is ignored (no non-extended 75 in the table); `ev_valid` stays 0.
